input_conditioner: RTL

- Upstream front end for the reaction-timer game controller.
- Takes the raw board inputs KEY0, KEY1 and SW[9:0] and synchronises each one to CLK_10MHZ.
- Debounces each input on its own channel.
- Outputs clean active-high levels plus single-cycle edge pulses, so the game FSM never sees bounce, metastability or repeated key presses.

---
 rtl/input_conditioner_if.sv | 28 ++
 rtl/input_conditioner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned key/switch outputs of the reaction-timer front end.
// master = board/game side, slave = input_conditioner.
interface input_conditioner_if;
  logic       KEY0;
  logic       KEY1;
  logic [9:0] SW;
  logic       KEY0_PRESSED;
  logic       KEY1_PRESSED;
  logic       KEY0_PRESS_PULSE;
  logic       KEY1_PRESS_PULSE;
  logic       KEY0_RELEASE_PULSE;
  logic       KEY1_RELEASE_PULSE;
  logic [9:0] SW_DB;
  logic [9:0] SW_RISE;
  logic [9:0] SW_FALL;

  modport master (
    output KEY0, KEY1, SW,
    input  KEY0_PRESSED, KEY1_PRESSED, KEY0_PRESS_PULSE, KEY1_PRESS_PULSE,
           KEY0_RELEASE_PULSE, KEY1_RELEASE_PULSE, SW_DB, SW_RISE, SW_FALL
  );

  modport slave (
    input  KEY0, KEY1, SW,
    output KEY0_PRESSED, KEY1_PRESSED, KEY0_PRESS_PULSE, KEY1_PRESS_PULSE,
           KEY0_RELEASE_PULSE, KEY1_RELEASE_PULSE, SW_DB, SW_RISE, SW_FALL
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces KEY0/KEY1/SW[9:0] into clean active-high levels
// plus single-cycle rise/fall pulses, one independent channel per input.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                CLK_10MHZ,
  input  logic                RST_N,
  input_conditioner_if.slave  bus
);

  localparam int unsigned     N_CH     = 12;
  localparam logic [N_CH-1:0] KEY_MASK = 12'h003;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE0, PEND1, STABLE1, PEND0} db_state_e;

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] chan;
  logic [N_CH-1:0] lvl;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  assign raw = {bus.SW, bus.KEY1, bus.KEY0};

  // Key flops hold the raw active-low level, so they reset to 1 (released)
  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= KEY_MASK;
      sync2 <= KEY_MASK;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign chan = sync2 ^ KEY_MASK;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl_q;
    logic             lvl_nxt;
    logic             rise_q;
    logic             rise_nxt;
    logic             fall_q;
    logic             fall_nxt;

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
      if (!RST_N) begin
        state  <= STABLE0;
        cnt    <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        lvl_q  <= lvl_nxt;
        rise_q <= rise_nxt;
        fall_q <= fall_nxt;
      end
    end

    // Entering a pending state counts the first new sample, so the level flips
    // on the DEBOUNCE_CYCLES-th consecutive new sample.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lvl_nxt   = lvl_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
        STABLE0: begin
          if (chan[g]) begin
            state_nxt = PEND1;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PEND1: begin
          if (!chan[g]) begin
            state_nxt = STABLE0;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE1;
            cnt_nxt   = '0;
            lvl_nxt   = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        STABLE1: begin
          if (!chan[g]) begin
            state_nxt = PEND0;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PEND0: begin
          if (chan[g]) begin
            state_nxt = STABLE1;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE0;
            cnt_nxt   = '0;
            lvl_nxt   = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = STABLE0;
          cnt_nxt   = '0;
          lvl_nxt   = 1'b0;
        end
      endcase
    end

    assign lvl[g]  = lvl_q;
    assign rise[g] = rise_q;
    assign fall[g] = fall_q;
  end

  assign bus.KEY0_PRESSED       = lvl[0];
  assign bus.KEY1_PRESSED       = lvl[1];
  assign bus.KEY0_PRESS_PULSE   = rise[0];
  assign bus.KEY1_PRESS_PULSE   = rise[1];
  assign bus.KEY0_RELEASE_PULSE = fall[0];
  assign bus.KEY1_RELEASE_PULSE = fall[1];
  assign bus.SW_DB              = lvl[11:2];
  assign bus.SW_RISE            = rise[11:2];
  assign bus.SW_FALL            = fall[11:2];

endmodule
